// File: rtl/register_file_rename.sv
// Architectural register file with per-register rename tags. Reads resolve
// combinationally against the committed state plus a same-cycle commit bypass.
module rf_read_port #(
  parameter int                 ENTRY_W  = 6,
  parameter logic [ENTRY_W-1:0] NULL_TAG = 6'd32,
  parameter int                 IDX_W    = 5
) (
  input  logic [IDX_W-1:0]   addr,
  input  logic               reg_busy,
  input  logic [ENTRY_W-1:0] reg_tag,
  input  logic [31:0]        reg_val,
  input  logic               cm_wr,
  input  logic [IDX_W-1:0]   cm_rd,
  input  logic [ENTRY_W-1:0] cm_entry,
  input  logic [31:0]        cm_value,
  output logic               busy,
  output logic [ENTRY_W-1:0] tag,
  output logic [31:0]        val
);
  always_comb begin
    busy = 1'b0;
    tag  = NULL_TAG;
    val  = reg_val;
    if (addr == '0) begin
      val = '0;
    end else if (reg_busy && cm_wr && cm_rd == addr && cm_entry == reg_tag) begin
      // producer is committing right now: forward its result
      val = cm_value;
    end else if (reg_busy) begin
      busy = 1'b1;
      tag  = reg_tag;
    end
  end
endmodule

module register_file_rename #(
  parameter int                 REG_NUM  = 32,
  parameter int                 ENTRY_W  = 6,
  parameter logic [ENTRY_W-1:0] NULL_TAG = 6'd32
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               rdy_in,
  input  logic               roll_back,
  input  logic               issue_valid,
  input  logic [4:0]         issue_rd,
  input  logic               issue_has_rd,
  input  logic [ENTRY_W-1:0] issue_entry,
  input  logic [4:0]         rs1_addr,
  input  logic [4:0]         rs2_addr,
  output logic               rs1_busy,
  output logic [ENTRY_W-1:0] rs1_tag,
  output logic [31:0]        rs1_val,
  output logic               rs2_busy,
  output logic [ENTRY_W-1:0] rs2_tag,
  output logic [31:0]        rs2_val,
  input  logic               commit_valid,
  input  logic               commit_has_rd,
  input  logic [4:0]         commit_rd,
  input  logic [ENTRY_W-1:0] commit_entry,
  input  logic [31:0]        commit_value
);
  localparam int NUM_LANES = 2;
  localparam int IDX_W     = 5;

  logic [REG_NUM-1:0][31:0]        regs_q, regs_d;
  logic [REG_NUM-1:0][ENTRY_W-1:0] tag_q, tag_d;
  logic [REG_NUM-1:0]              busy_q, busy_d;

  logic cm_wr, commit_en, issue_en;
  assign cm_wr     = commit_valid && commit_has_rd;
  assign commit_en = rdy_in && cm_wr && commit_rd != '0;
  assign issue_en  = rdy_in && !roll_back && issue_valid && issue_has_rd && issue_rd != '0;

  // Issue is applied after commit so a same-register issue owns the tag.
  always_comb begin
    regs_d = regs_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (commit_en) begin
      regs_d[commit_rd] = commit_value;
      if (tag_q[commit_rd] == commit_entry) begin
        busy_d[commit_rd] = 1'b0;
        tag_d[commit_rd]  = NULL_TAG;
      end
    end
    if (rdy_in && roll_back) begin
      busy_d = '0;
      tag_d  = {REG_NUM{NULL_TAG}};
    end else if (issue_en) begin
      busy_d[issue_rd] = 1'b1;
      tag_d[issue_rd]  = issue_entry;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      regs_q <= '0;
      tag_q  <= {REG_NUM{NULL_TAG}};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
    end
  end

  logic [NUM_LANES-1:0][IDX_W-1:0]   rs_addr;
  logic [NUM_LANES-1:0]              rd_busy;
  logic [NUM_LANES-1:0][ENTRY_W-1:0] rd_tag;
  logic [NUM_LANES-1:0][31:0]        rd_val;

  assign rs_addr = {rs2_addr, rs1_addr};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_rd
    rf_read_port #(.ENTRY_W(ENTRY_W), .NULL_TAG(NULL_TAG), .IDX_W(IDX_W)) u_port (
      .addr    (rs_addr[g]),
      .reg_busy(busy_q[rs_addr[g]]),
      .reg_tag (tag_q[rs_addr[g]]),
      .reg_val (regs_q[rs_addr[g]]),
      .cm_wr   (cm_wr),
      .cm_rd   (commit_rd),
      .cm_entry(commit_entry),
      .cm_value(commit_value),
      .busy    (rd_busy[g]),
      .tag     (rd_tag[g]),
      .val     (rd_val[g])
    );
  end

  assign rs1_busy = rd_busy[0];
  assign rs1_tag  = rd_tag[0];
  assign rs1_val  = rd_val[0];
  assign rs2_busy = rd_busy[1];
  assign rs2_tag  = rd_tag[1];
  assign rs2_val  = rd_val[1];
endmodule

// File: tb/tb_register_file_rename.sv
// Bench for register_file_rename: array-based reference model checked every
// negedge, plus directed literal expectations.
module tb_register_file_rename;
  logic clk = 1'b0;
  logic rst_n, rdy, roll_back;
  logic issue_valid, issue_has_rd;
  logic [4:0] issue_rd, rs1_addr, rs2_addr, commit_rd;
  logic [5:0] issue_entry, commit_entry;
  logic commit_valid, commit_has_rd;
  logic [31:0] commit_value;
  logic rs1_busy, rs2_busy;
  logic [5:0] rs1_tag, rs2_tag;
  logic [31:0] rs1_val, rs2_val;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  register_file_rename dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .roll_back(roll_back),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_has_rd(issue_has_rd),
    .issue_entry(issue_entry), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs1_val(rs1_val),
    .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_val(rs2_val),
    .commit_valid(commit_valid), .commit_has_rd(commit_has_rd), .commit_rd(commit_rd),
    .commit_entry(commit_entry), .commit_value(commit_value)
  );

  // reference state: value, pending producer (32 = none) per register
  logic [31:0] m_regs [32];
  int          m_tag  [32];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] <= 0; m_tag[i] <= 32; end
    end else if (rdy) begin
      if (commit_valid && commit_has_rd && commit_rd != 0) begin
        m_regs[commit_rd] <= commit_value;
        if (m_tag[commit_rd] == int'(commit_entry)) m_tag[commit_rd] <= 32;
      end
      if (roll_back) begin
        for (int i = 0; i < 32; i++) m_tag[i] <= 32;
      end else if (issue_valid && issue_has_rd && issue_rd != 0) begin
        m_tag[issue_rd] <= int'(issue_entry);
      end
    end
  end

  function automatic void exp_rd(input int a, output logic b, output logic [5:0] t,
                                 output logic [31:0] v);
    b = 0; t = 6'd32; v = m_regs[a];
    if (a == 0) v = 0;
    else if (m_tag[a] != 32) begin
      if (commit_valid && commit_has_rd && int'(commit_rd) == a && int'(commit_entry) == m_tag[a])
        v = commit_value;
      else begin b = 1; t = 6'(m_tag[a]); end
    end
  endfunction

  always @(negedge clk) begin
    logic eb; logic [5:0] et; logic [31:0] ev;
    exp_rd(int'(rs1_addr), eb, et, ev);
    checks++;
    if (rs1_busy !== eb || rs1_tag !== et || rs1_val !== ev) begin
      errors++;
      $display("FAIL model_rs1 x%0d: got busy=%b tag=%0d val=%h want busy=%b tag=%0d val=%h",
               rs1_addr, rs1_busy, rs1_tag, rs1_val, eb, et, ev);
    end
    exp_rd(int'(rs2_addr), eb, et, ev);
    checks++;
    if (rs2_busy !== eb || rs2_tag !== et || rs2_val !== ev) begin
      errors++;
      $display("FAIL model_rs2 x%0d: got busy=%b tag=%0d val=%h want busy=%b tag=%0d val=%h",
               rs2_addr, rs2_busy, rs2_tag, rs2_val, eb, et, ev);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic clr();
    issue_valid = 0; issue_has_rd = 0; issue_rd = 0; issue_entry = 0;
    commit_valid = 0; commit_has_rd = 0; commit_rd = 0; commit_entry = 0; commit_value = 0;
    roll_back = 0;
  endtask

  task automatic iss(input int rd, input int e);
    issue_valid = 1; issue_has_rd = 1; issue_rd = 5'(rd); issue_entry = 6'(e);
  endtask

  task automatic cmt(input int rd, input int e, input logic [31:0] v);
    commit_valid = 1; commit_has_rd = 1; commit_rd = 5'(rd); commit_entry = 6'(e); commit_value = v;
  endtask

  initial begin
    clr(); rst_n = 0; rdy = 1; rs1_addr = 0; rs2_addr = 0;
    cyc(); cyc(); rst_n = 1;
    // reset state and plain commit write
    rs1_addr = 5; rs2_addr = 0; #1;
    chk("rst_x5_busy", 32'(rs1_busy), 0); chk("rst_x5_tag", 32'(rs1_tag), 32);
    chk("rst_x5_val", rs1_val, 0); chk("rst_x0_val", rs2_val, 0);
    cmt(5, 3, 32'hDEADBEEF); cyc(); clr(); #1;
    chk("wr_x5_busy", 32'(rs1_busy), 0); chk("wr_x5_val", rs1_val, 32'hDEADBEEF);
    // issue then bypassed commit
    iss(7, 4); cyc(); clr(); rs1_addr = 7; #1;
    chk("iss_x7_busy", 32'(rs1_busy), 1); chk("iss_x7_tag", 32'(rs1_tag), 4);
    cmt(7, 4, 32'h12); #1;
    chk("byp_x7_busy", 32'(rs1_busy), 0); chk("byp_x7_tag", 32'(rs1_tag), 32);
    chk("byp_x7_val", rs1_val, 32'h12);
    cyc(); clr(); #1;
    chk("post_x7_busy", 32'(rs1_busy), 0); chk("post_x7_val", rs1_val, 32'h12);
    // stale commit keeps the younger producer
    iss(7, 4); cyc(); iss(7, 9); cyc(); clr(); cmt(7, 4, 32'h55); cyc(); clr(); #1;
    chk("stale_busy", 32'(rs1_busy), 1); chk("stale_tag", 32'(rs1_tag), 9);
    chk("stale_val", rs1_val, 32'h55);
    cmt(7, 9, 32'h66); cyc(); clr(); #1;
    chk("young_busy", 32'(rs1_busy), 0); chk("young_val", rs1_val, 32'h66);
    // same-cycle issue and commit to one register
    iss(3, 2); cyc(); clr(); iss(3, 10); cmt(3, 2, 32'h77); cyc(); clr(); rs1_addr = 3; #1;
    chk("ic_busy", 32'(rs1_busy), 1); chk("ic_tag", 32'(rs1_tag), 10);
    chk("ic_val", rs1_val, 32'h77);
    // rollback with same-cycle commit and dropped issue
    iss(1, 5); cyc(); iss(2, 6); cyc(); clr();
    roll_back = 1; cmt(8, 11, 32'hA5); iss(9, 7); cyc(); clr();
    rs1_addr = 8; rs2_addr = 9; #1;
    chk("rb_x8_val", rs1_val, 32'hA5); chk("rb_x9_busy", 32'(rs2_busy), 0);
    rs1_addr = 1; rs2_addr = 2; #1;
    chk("rb_x1_busy", 32'(rs1_busy), 0); chk("rb_x2_busy", 32'(rs2_busy), 0);
    rs1_addr = 3; #1; chk("rb_x3_busy", 32'(rs1_busy), 0);
    // x0 immunity, rdy hold, reset while busy
    iss(0, 1); cmt(0, 1, 32'hFF); cyc(); clr(); rs1_addr = 0; #1;
    chk("x0_busy", 32'(rs1_busy), 0); chk("x0_val", rs1_val, 0);
    rdy = 0; iss(4, 3); cmt(6, 1, 32'h3C); cyc(); rdy = 1; clr(); rs1_addr = 4; rs2_addr = 6; #1;
    chk("hold_x4_busy", 32'(rs1_busy), 0); chk("hold_x6_val", rs2_val, 0);
    iss(4, 3); cyc(); clr(); #1; chk("x4_busy", 32'(rs1_busy), 1);
    cmt(4, 20, 32'h99); cyc(); clr(); #1;
    chk("x4_nomatch_busy", 32'(rs1_busy), 1); chk("x4_nomatch_val", rs1_val, 32'h99);
    rst_n = 0; cyc(); rst_n = 1; #1;
    chk("rst2_busy", 32'(rs1_busy), 0); chk("rst2_tag", 32'(rs1_tag), 32);
    chk("rst2_val", rs1_val, 0);
    // mixed traffic, checked by the model every cycle
    for (int n = 0; n < 400; n++) begin
      int r;
      clr();
      rdy = ($urandom_range(0, 9) != 0);
      roll_back = ($urandom_range(0, 19) == 0);
      rs1_addr = 5'($urandom_range(0, 7)); rs2_addr = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        issue_valid = 1; issue_has_rd = ($urandom_range(0, 4) != 0);
        issue_rd = 5'($urandom_range(0, 7)); issue_entry = 6'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(0, 7);
        commit_valid = 1; commit_has_rd = ($urandom_range(0, 4) != 0); commit_rd = 5'(r);
        commit_entry = ($urandom_range(0, 2) != 0 && m_tag[r] != 32) ? 6'(m_tag[r])
                                                                    : 6'($urandom_range(0, 31));
        commit_value = $urandom;
      end
      if ($urandom_range(0, 99) == 0) rst_n = 0; else rst_n = 1;
      cyc();
    end
    clr(); rst_n = 1; rdy = 1;
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/register_file_rename.md
Name: register_file_rename

Overview:
- 32 x 32-bit architectural register file with a per-register rename tag (ROB entry index). Sits downstream of the reorder buffer commit broadcast and alongside issue.
- Decode/issue reads source operands and gets either a ready value or the ROB entry that will produce it.
- Issue marks the destination register busy with its ROB entry.
- ROB commit writes back the result and releases the tag when it still matches.

Parameters:
- REG_NUM, 32, number of architectural registers (index width 5).
- ENTRY_W, 6, tag width: 5-bit ROB index plus a NULL encoding.
- NULL_TAG, 6'd32, tag value meaning "no pending producer".

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  synchronous reset, active-low
- rdy_in  input  1  global ready; low = hold all state
- roll_back  input  1  mispredict flush
- issue_valid  input  1  instruction issued this cycle
- issue_rd  input  5  destination register of issued instruction
- issue_has_rd  input  1  issued instruction writes rd (0 for store/branch)
- issue_entry  input  ENTRY_W  ROB entry assigned to issued instruction
- rs1_addr  input  5  source 1 index
- rs2_addr  input  5  source 2 index
- rs1_busy  output  1  source 1 awaits a producer
- rs1_tag  output  ENTRY_W  producer entry if busy, else NULL_TAG
- rs1_val  output  32  value, valid when !rs1_busy
- rs2_busy / rs2_tag / rs2_val  output  1 / ENTRY_W / 32  same for source 2
- commit_valid  input  1  ROB commit strobe
- commit_has_rd  input  1  committing instruction writes rd
- commit_rd  input  5  commit destination
- commit_entry  input  ENTRY_W  committing ROB entry
- commit_value  input  32  committed result

Behaviour:
- State: regs[32] (32 bits), tag[32] (ENTRY_W), busy[32].
- Reset (rst_n_in==0 at posedge): regs=0, busy=0, tag=NULL_TAG.
  - Outputs follow combinationally: busy=0, tag=NULL_TAG, val=0.
  - Reset overrides all other inputs.
- rdy_in low: no state update. Read paths stay live.
- Reads are combinational (0 latency). For each source, priority order:
  - index 0: busy=0, tag=NULL_TAG, val=0.
  - busy[idx] and commit_valid&&commit_has_rd&&commit_rd==idx&&commit_entry==tag[idx]: bypass, busy=0, tag=NULL_TAG, val=commit_value.
  - busy[idx]: busy=1, tag=tag[idx], val=regs[idx].
  - otherwise: busy=0, tag=NULL_TAG, val=regs[idx].
- A same-cycle issue never affects that cycle's reads. A source equal to its own rd (e.g. add x1,x1,x1) sees the pre-issue state.
- Commit (posedge, rdy_in high, commit_valid&&commit_has_rd&&commit_rd!=0):
  - regs[commit_rd] <= commit_value unconditionally.
  - If tag[commit_rd]==commit_entry: busy <= 0, tag <= NULL_TAG. Otherwise tag and busy are kept (a younger producer exists).
- Issue (posedge, rdy_in high, !roll_back, issue_valid&&issue_has_rd&&issue_rd!=0): busy[issue_rd] <= 1, tag[issue_rd] <= issue_entry.
- Issue and commit to the same rd in the same cycle: the value is written, and the issue tag/busy wins.
- roll_back (rdy_in high):
  - All busy <= 0, all tags <= NULL_TAG.
  - regs retained. A same-cycle commit still writes its value.
  - A same-cycle issue is dropped.
- x0 is never written, never busy, and always reads 0.
- No wrap-around concerns: tags are opaque. NULL_TAG is never presented as issue_entry.

Test Plan:
- Reset then read x5/x0 -> busy=0, tag=32, val=0. Write via commit rd=5, entry=3, value=0xDEADBEEF with busy[5]=0 -> next cycle rs1_addr=5 gives busy=0, val=0xDEADBEEF.
- Issue rd=7, entry=4; next cycle read x7 -> busy=1, tag=4. Commit rd=7, entry=4, value=0x12 while reading x7 -> same cycle busy=0, val=0x12 (bypass); next cycle busy=0, val=0x12.
- Issue rd=7 entry=4, then issue rd=7 entry=9, then commit rd=7 entry=4, value=0x55 -> x7 busy=1, tag=9, val=0x55. Commit entry=9, value=0x66 -> busy=0, val=0x66.
- Same cycle: issue rd=3 entry=10 and commit rd=3 entry=2 (tag[3]==2), value=0x77 -> next cycle busy=1, tag=10, regs[3]=0x77.
- Issue rd=1 entry=5, rd=2 entry=6; then roll_back together with commit rd=8 value=0xA5 and issue rd=9 entry=7 -> all busy=0, x8=0xA5, x9 not busy.
- Issue rd=0 / commit rd=0 value=0xFF -> x0 reads busy=0, val=0. With rdy_in=0, issue rd=4 -> x4 stays not busy. Reset asserted while x4 busy -> busy cleared and val=0 next cycle.
